leaky_integrate_fire_neuron: RTL and testbench

Single leaky integrate-and-fire (LIF) neuron for the RSNN fabric. On each enabled clock cycle it leaks its membrane potential by a programmable decay and adds the input current. When the potential reaches a programmable threshold it emits a one-cycle spike, clears the potential and enters a programmable refractory period. All configuration is supplied as run-time ports, so a neuron array can share one configuration bus.

---
 rtl/lif_pkg.sv | 24 ++
 rtl/lif_refractory_counter.sv | 45 ++++
 rtl/leaky_integrate_fire_neuron.sv | 81 ++++++++
 tb/tb_leaky_integrate_fire_neuron.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the leaky integrate-and-fire neuron.
// Arithmetic runs on a wide scratch type so that saturation and the floor are explicit.
package lif_pkg;

    localparam int LIF_DATA_W = 8;
    localparam int LIF_CALC_W = 32;

    typedef logic [LIF_DATA_W-1:0] lif_state_t;
    typedef logic [LIF_CALC_W-1:0] lif_calc_t;

    // Subtract that clamps at zero instead of wrapping.
    function automatic lif_calc_t lif_floor_sub(input lif_calc_t a, input lif_calc_t b);
        return (a > b) ? (a - b) : '0;
    endfunction

    // Add that clamps at max_val. Both operands must be narrower than LIF_CALC_W.
    function automatic lif_calc_t lif_sat_add(input lif_calc_t a, input lif_calc_t b,
                                              input lif_calc_t max_val);
        lif_calc_t s;
        s = a + b;
        return (s > max_val) ? max_val : s;
    endfunction

endpackage

// File: rtl/lif_refractory_counter.sv
// Refractory down-counter: loads on a spike, counts down on enabled cycles, flags non-zero.
// State changes only when en_i is high; reset clears it asynchronously.
module lif_refractory_counter
    import lif_pkg::*;
#(
    parameter int DATA_W = LIF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_val_i,
    output logic [DATA_W-1:0] cnt_o,
    output logic              busy_o
);

    localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] refr_cnt_q;
    logic [DATA_W-1:0] refr_cnt_d;

    assign busy_o = |refr_cnt_q;
    assign cnt_o  = refr_cnt_q;

    // A running count always wins over a load; load only happens when idle.
    always_comb begin
        refr_cnt_d = refr_cnt_q;
        if (en_i) begin
            if (busy_o) begin
                refr_cnt_d = refr_cnt_q - CNT_ONE;
            end else if (load_i) begin
                refr_cnt_d = load_val_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            refr_cnt_q <= '0;
        end else begin
            refr_cnt_q <= refr_cnt_d;
        end
    end

endmodule

// File: rtl/leaky_integrate_fire_neuron.sv
// Single LIF neuron: leak, integrate with saturation, fire at threshold, then refractory hold.
// spike_out is registered and appears the cycle after the crossing edge.
module leaky_integrate_fire_neuron
    import lif_pkg::*;
#(
    parameter int DATA_W = LIF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] input_current,
    input  logic [DATA_W-1:0] threshold,
    input  logic [DATA_W-1:0] decay,
    input  logic [DATA_W-1:0] refractory_period,
    output logic              spike_out
);

    localparam lif_calc_t MEM_MAX = lif_calc_t'((64'd1 << DATA_W) - 64'd1);

    logic [DATA_W-1:0] membrane_potential;
    logic [DATA_W-1:0] membrane_potential_d;
    logic              spike_q;
    logic              spike_d;
    logic [DATA_W-1:0] refr_cnt;
    logic              refr_busy;
    logic              fire;
    logic              load;

    lif_calc_t                     leaked;
    lif_calc_t                     sum;
    logic [DATA_W-1:0]             sum_lo;
    logic [LIF_CALC_W-DATA_W-1:0]  unused_sum_hi;

    assign leaked = lif_floor_sub(lif_calc_t'(membrane_potential), lif_calc_t'(decay));
    assign sum    = lif_sat_add(leaked, lif_calc_t'(input_current), MEM_MAX);
    assign fire   = (sum >= lif_calc_t'(threshold));
    // sum is already clamped to MEM_MAX, so the high bits are always zero.
    assign {unused_sum_hi, sum_lo} = sum;

    assign load = enable & ~refr_busy & fire;

    lif_refractory_counter #(
        .DATA_W (DATA_W)
    ) u_refr (
        .clk_i      (clk),
        .rst_i      (reset),
        .en_i       (enable),
        .load_i     (load),
        .load_val_i (refractory_period),
        .cnt_o      (refr_cnt),
        .busy_o     (refr_busy)
    );

    always_comb begin
        membrane_potential_d = membrane_potential;
        spike_d              = 1'b0;
        if (enable) begin
            if (refr_busy) begin
                membrane_potential_d = '0;
            end else if (fire) begin
                membrane_potential_d = '0;
                spike_d              = 1'b1;
            end else begin
                membrane_potential_d = sum_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            membrane_potential <= '0;
            spike_q            <= 1'b0;
        end else begin
            membrane_potential <= membrane_potential_d;
            spike_q            <= spike_d;
        end
    end

    assign spike_out = spike_q;

endmodule

// File: tb/tb_leaky_integrate_fire_neuron.sv
// Scoreboard bench for the LIF neuron: directed steps push expected state, a monitor compares.
module tb_leaky_integrate_fire_neuron;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] input_current;
    logic [7:0] threshold;
    logic [7:0] decay;
    logic [7:0] refractory_period;
    logic       spike_out;

    int cfg_thr;
    int cfg_dec;
    int cfg_refr;

    int n_cmp;
    int n_fail;

    typedef struct {
        int mp;
        int spk;
        int rc;
    } exp_t;

    exp_t exp_q[$];

    leaky_integrate_fire_neuron #(.DATA_W(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .input_current     (input_current),
        .threshold         (threshold),
        .decay             (decay),
        .refractory_period (refractory_period),
        .spike_out         (spike_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; expected state after the coming rising edge.
    task automatic step(input int en, input int cur, input int mp, input int spk, input int rc);
        exp_t e;
        @(negedge clk);
        #1;
        enable            = en[0];
        input_current     = 8'(cur);
        threshold         = 8'(cfg_thr);
        decay             = 8'(cfg_dec);
        refractory_period = 8'(cfg_refr);
        e.mp  = mp;
        e.spk = spk;
        e.rc  = rc;
        exp_q.push_back(e);
    endtask

    task automatic refr_drain(input int cur);
        for (int i = 9; i >= 0; i--) step(1, cur, 0, 0, i);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("membrane_potential", int'(dut.membrane_potential), e.mp);
            check("spike_out", int'(spike_out), e.spk);
            check("refr_cnt", int'(dut.refr_cnt), e.rc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cfg_thr = 127; cfg_dec = 1; cfg_refr = 10;
        reset = 1'b0; enable = 1'b0; input_current = 8'd0;
        threshold = 8'd127; decay = 8'd1; refractory_period = 8'd10;

        // Asynchronous reset between clock edges, with live inputs.
        #2;
        enable = 1'b1; input_current = 8'd60; reset = 1'b1;
        #1;
        check("reset_mp", int'(dut.membrane_potential), 0);
        check("reset_spike", int'(spike_out), 0);
        check("reset_refr", int'(dut.refr_cnt), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        enable = 1'b0; reset = 1'b0;

        // Spike and refractory, twice.
        step(1, 60, 60, 0, 0);
        step(1, 60, 119, 0, 0);
        step(1, 60, 0, 1, 10);
        refr_drain(60);
        step(1, 60, 60, 0, 0);
        step(1, 60, 119, 0, 0);
        step(1, 60, 0, 1, 10);
        refr_drain(60);

        // Enable freeze at 119, then fire on the first enabled edge.
        step(1, 60, 60, 0, 0);
        step(1, 60, 119, 0, 0);
        step(0, 60, 119, 0, 0);
        step(0, 60, 119, 0, 0);
        step(1, 60, 0, 1, 10);
        refr_drain(60);

        // Slow leak, no refractory: 5, 9, 13 ... spike on the 32nd cycle.
        cfg_refr = 0;
        for (int n = 0; n < 31; n++) step(1, 5, 5 + 4 * n, 0, 0);
        step(1, 5, 0, 1, 0);
        step(1, 5, 5, 0, 0);

        // Leak floors at zero.
        cfg_dec = 0;
        step(1, 5, 10, 0, 0);
        cfg_dec = 200;
        step(1, 0, 0, 0, 0);

        // Saturation at 255 instead of wrapping.
        cfg_thr = 255; cfg_dec = 0;
        step(1, 200, 200, 0, 0);
        step(1, 200, 0, 1, 0);

        // Zero threshold fires on every non-refractory cycle.
        cfg_thr = 0;
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);

        // Reset three cycles into a refractory period.
        cfg_thr = 127; cfg_dec = 1; cfg_refr = 10;
        step(1, 60, 60, 0, 0);
        step(1, 60, 119, 0, 0);
        step(1, 60, 0, 1, 10);
        step(1, 60, 0, 0, 9);
        step(1, 60, 0, 0, 8);
        step(1, 60, 0, 0, 7);
        @(negedge clk); #1;
        enable = 1'b0; reset = 1'b1;
        #1;
        check("midrefr_reset_refr", int'(dut.refr_cnt), 0);
        check("midrefr_reset_mp", int'(dut.membrane_potential), 0);
        check("midrefr_reset_spike", int'(spike_out), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        step(1, 60, 60, 0, 0);
        step(1, 60, 119, 0, 0);
        step(1, 60, 0, 1, 10);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
